// File: rtl/pattern_tx_if.sv
// Pattern transmitter bus: start request with pattern/reps payload, serial output and status.
interface pattern_tx_if #(
  parameter int unsigned WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] data;
  logic [2:0]       reps;
  logic             e;
  logic             bit_valid;
  logic             busy;
  logic             done;

  modport master (output start, output data, output reps,
                  input  e, input bit_valid, input busy, input done);
  modport slave  (input  start, input data, input reps,
                  output e, output bit_valid, output busy, output done);
endinterface

// File: rtl/pattern_tx.sv
// Serial pattern transmitter: emits a captured WIDTH-bit pattern MSB-first, reps+1 times, GAP idle cycles apart.
// Optional even-parity bit after each frame when PATTERN_TX_PARITY_EN is defined.
module pattern_tx #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned GAP   = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  pattern_tx_if.slave  bus
);

`ifdef PATTERN_TX_PARITY_EN
  localparam int unsigned FRAME_LEN = WIDTH + 1;
`else
  localparam int unsigned FRAME_LEN = WIDTH;
`endif
  localparam int unsigned BIT_CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned GAP_CNT_W = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam int unsigned GAP_LAST  = (GAP > 0) ? GAP - 1 : 0;
  localparam int unsigned FRM_W     = 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                 r_state, w_state_nxt;
  logic [FRAME_LEN-1:0]   r_shift, w_shift_nxt;
  logic [FRAME_LEN-1:0]   r_pat,   w_pat_nxt;
  logic [FRM_W-1:0]       r_frm,   w_frm_nxt;
  logic [BIT_CNT_W-1:0]   r_bit,   w_bit_nxt;
  logic [GAP_CNT_W-1:0]   r_gap,   w_gap_nxt;
  logic                   r_e, r_bit_valid, r_busy, r_done;
  logic                   w_e_nxt, w_bit_valid_nxt, w_busy_nxt, w_done_nxt;
  logic [FRAME_LEN-1:0]   w_frame;

`ifdef PATTERN_TX_PARITY_EN
  assign w_frame = {bus.data, ^bus.data};
`else
  assign w_frame = bus.data;
`endif

  // State, datapath and registered Moore outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_shift     <= '0;
      r_pat       <= '0;
      r_frm       <= '0;
      r_bit       <= '0;
      r_gap       <= '0;
      r_e         <= 1'b0;
      r_bit_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_shift     <= w_shift_nxt;
      r_pat       <= w_pat_nxt;
      r_frm       <= w_frm_nxt;
      r_bit       <= w_bit_nxt;
      r_gap       <= w_gap_nxt;
      r_e         <= w_e_nxt;
      r_bit_valid <= w_bit_valid_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
    end
  end

  // Next state; outputs are decoded from the next state so they register alongside it
  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_pat_nxt   = r_pat;
    w_frm_nxt   = r_frm;
    w_bit_nxt   = r_bit;
    w_gap_nxt   = r_gap;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_nxt = S_SEND;
          w_shift_nxt = w_frame;
          w_pat_nxt   = w_frame;
          w_frm_nxt   = bus.reps;
          w_bit_nxt   = '0;
        end
      end
      S_SEND: begin
        w_shift_nxt = r_shift << 1;
        w_bit_nxt   = BIT_CNT_W'(r_bit + BIT_CNT_W'(1));
        if (r_bit == BIT_CNT_W'(FRAME_LEN - 1)) begin
          w_bit_nxt = '0;
          if (r_frm != '0) begin
            w_frm_nxt   = FRM_W'(r_frm - FRM_W'(1));
            w_shift_nxt = r_pat;
            w_gap_nxt   = '0;
            w_state_nxt = (GAP > 0) ? S_GAP : S_SEND;
          end else begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_GAP: begin
        if (r_gap == GAP_CNT_W'(GAP_LAST)) begin
          w_gap_nxt   = '0;
          w_state_nxt = S_SEND;
        end else begin
          w_gap_nxt = GAP_CNT_W'(r_gap + GAP_CNT_W'(1));
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase

    w_e_nxt         = (w_state_nxt == S_SEND) && w_shift_nxt[FRAME_LEN-1];
    w_bit_valid_nxt = (w_state_nxt == S_SEND);
    w_busy_nxt      = (w_state_nxt != S_IDLE);
    w_done_nxt      = (w_state_nxt == S_DONE);
  end

  assign bus.e         = r_e;
  assign bus.bit_valid = r_bit_valid;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;

endmodule

// File: tb/tb_pattern_tx.sv
// Self-checking bench for pattern_tx: directed plan cases plus randomized transactions against a cycle-list model.
module tb_pattern_tx;
  localparam int unsigned WIDTH = 4;
  localparam int unsigned GAP   = 2;

  typedef struct packed {
    logic e;
    logic bv;
    logic busy;
    logic done;
  } smp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pattern_tx_if #(.WIDTH(WIDTH)) if0 ();
  pattern_tx_if #(.WIDTH(WIDTH)) ifg ();

  pattern_tx #(.WIDTH(WIDTH), .GAP(GAP)) dut    (.clk(clk), .rst_n(rst_n), .bus(if0));
  pattern_tx #(.WIDTH(WIDTH), .GAP(0))   dut_g0 (.clk(clk), .rst_n(rst_n), .bus(ifg));

  smp_t exp_q[$];
  smp_t obs_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic smp_t mk(input logic e, input logic bv, input logic bs, input logic dn);
    smp_t s;
    s = {e, bv, bs, dn};
    return s;
  endfunction

  function automatic smp_t sample(input bit g0);
    if (g0) return mk(ifg.e, ifg.bit_valid, ifg.busy, ifg.done);
    return mk(if0.e, if0.bit_valid, if0.busy, if0.done);
  endfunction

  // Model: list of per-cycle outputs from cycle 1 after acceptance through the IDLE cycle after DONE
  function automatic void build_exp(input logic [WIDTH-1:0] d, input int r, input int gap, input bit append);
    if (!append) exp_q.delete();
    for (int f = 0; f <= r; f++) begin
      for (int i = WIDTH - 1; i >= 0; i--) exp_q.push_back(mk(d[i], 1'b1, 1'b1, 1'b0));
`ifdef PATTERN_TX_PARITY_EN
      exp_q.push_back(mk(($countones(d) % 2) == 1, 1'b1, 1'b1, 1'b0));
`endif
      if (f < r) for (int g = 0; g < gap; g++) exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0));
    end
    exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1));
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0));
  endfunction

  // Drive one transaction and record outputs; optional noise toggles start/data/reps while busy
  task automatic run(input logic [WIDTH-1:0] d, input logic [2:0] r, input bit noise, input bit g0);
    int n;
    n = exp_q.size();
    obs_q.delete();
    if (g0) begin ifg.start = 1'b1; ifg.data = d; ifg.reps = r; end
    else    begin if0.start = 1'b1; if0.data = d; if0.reps = r; end
    @(posedge clk); #1;
    if (g0) begin ifg.start = 1'b0; ifg.data = WIDTH'($urandom); ifg.reps = 3'($urandom); end
    else    begin if0.start = 1'b0; if0.data = WIDTH'($urandom); if0.reps = 3'($urandom); end
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      obs_q.push_back(sample(g0));
      if (noise) begin
        logic st;
        st = exp_q[k].busy ? 1'($urandom) : 1'b0;
        if (g0) begin ifg.start = st; ifg.data = WIDTH'($urandom); ifg.reps = 3'($urandom); end
        else    begin if0.start = st; if0.data = WIDTH'($urandom); if0.reps = 3'($urandom); end
      end
    end
    if0.start = 1'b0;
    ifg.start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    if0.start = 1'b0; if0.data = '0; if0.reps = '0;
    ifg.start = 1'b0; ifg.data = '0; ifg.reps = '0;
    #12;
    checks++;
    if (sample(0) !== mk(0, 0, 0, 0)) begin
      errors++; $display("FAIL reset_dut got %b exp 0000", sample(0));
    end
    checks++;
    if (sample(1) !== mk(0, 0, 0, 0)) begin
      errors++; $display("FAIL reset_dut_g0 got %b exp 0000", sample(1));
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (sample(0) !== mk(0, 0, 0, 0)) begin
      errors++; $display("FAIL reset_idle got %b exp 0000", sample(0));
    end
  endtask

  task automatic test_directed();
    logic [WIDTH-1:0] pats [3];
    int               rps  [3];
    pats[0] = 4'b1101; rps[0] = 0;
    pats[1] = 4'b1101; rps[1] = 2;
    pats[2] = 4'b1001; rps[2] = 0;
    for (int t = 0; t < 3; t++) begin
      build_exp(pats[t], rps[t], GAP, 0);
      run(pats[t], 3'(rps[t]), 0, 0);
      for (int k = 0; k < exp_q.size(); k++) begin
        checks++;
        if (obs_q[k] !== exp_q[k]) begin
          errors++;
          $display("FAIL directed_%0d cyc %0d got e/bv/busy/done=%b exp %b", t, k + 1, obs_q[k], exp_q[k]);
        end
      end
    end
  endtask

  task automatic test_gap0();
    build_exp(4'b1011, 1, 0, 0);
    run(4'b1011, 3'd1, 0, 1);
    for (int k = 0; k < exp_q.size(); k++) begin
      checks++;
      if (obs_q[k] !== exp_q[k]) begin
        errors++;
        $display("FAIL gap0 cyc %0d got %b exp %b", k + 1, obs_q[k], exp_q[k]);
      end
    end
  endtask

  task automatic test_start_ignored();
    build_exp(4'b1101, 0, GAP, 0);
    obs_q.delete();
    if0.start = 1'b1; if0.data = 4'b1101; if0.reps = 3'd0;
    @(posedge clk); #1;
    if0.start = 1'b0;
    for (int k = 0; k < exp_q.size(); k++) begin
      @(negedge clk);
      obs_q.push_back(sample(0));
      // High during cycle 2, and again during the DONE cycle
      if (k == 1 || exp_q[k].done) begin if0.start = 1'b1; if0.data = 4'b0000; if0.reps = 3'd7; end
      else if0.start = 1'b0;
    end
    if0.start = 1'b0;
    for (int k = 0; k < exp_q.size(); k++) begin
      checks++;
      if (obs_q[k] !== exp_q[k]) begin
        errors++;
        $display("FAIL start_ignored cyc %0d got %b exp %b", k + 1, obs_q[k], exp_q[k]);
      end
    end
    build_exp(4'b0110, 1, GAP, 0);
    run(4'b0110, 3'd1, 0, 0);
    for (int k = 0; k < exp_q.size(); k++) begin
      checks++;
      if (obs_q[k] !== exp_q[k]) begin
        errors++;
        $display("FAIL start_after cyc %0d got %b exp %b", k + 1, obs_q[k], exp_q[k]);
      end
    end
  endtask

  task automatic test_mid_reset();
    if0.start = 1'b1; if0.data = 4'b1101; if0.reps = 3'd2;
    @(posedge clk); #1;
    if0.start = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (sample(0) !== mk(0, 1, 1, 0)) begin
      errors++; $display("FAIL pre_reset_bit3 got %b exp 0110", sample(0));
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (sample(0) !== mk(0, 0, 0, 0)) begin
      errors++; $display("FAIL mid_reset_async got %b exp 0000", sample(0));
    end
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (sample(0) !== mk(0, 0, 0, 0)) begin
        errors++; $display("FAIL post_reset_idle cyc %0d got %b exp 0000", k, sample(0));
      end
    end
    build_exp(4'b1010, 0, GAP, 0);
    run(4'b1010, 3'd0, 0, 0);
    for (int k = 0; k < exp_q.size(); k++) begin
      checks++;
      if (obs_q[k] !== exp_q[k]) begin
        errors++;
        $display("FAIL post_reset_tx cyc %0d got %b exp %b", k + 1, obs_q[k], exp_q[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int n;
    build_exp(4'b1001, 1, GAP, 0);
    build_exp(4'b1001, 1, GAP, 1);
    build_exp(4'b1001, 1, GAP, 1);
    n = exp_q.size();
    exp_q.push_back(mk(0, 0, 0, 0));
    obs_q.delete();
    if0.start = 1'b1; if0.data = 4'b1001; if0.reps = 3'd1;
    @(posedge clk); #1;
    for (int k = 0; k < exp_q.size(); k++) begin
      @(negedge clk);
      obs_q.push_back(sample(0));
      if (k == n - 1) if0.start = 1'b0;
    end
    for (int k = 0; k < exp_q.size(); k++) begin
      checks++;
      if (obs_q[k] !== exp_q[k]) begin
        errors++;
        $display("FAIL back_to_back cyc %0d got %b exp %b", k + 1, obs_q[k], exp_q[k]);
      end
    end
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] d;
    logic [2:0]       r;
    bit               g0;
    for (int t = 0; t < 24; t++) begin
      g0 = (t % 2) == 1;
      d  = WIDTH'($urandom);
      r  = 3'($urandom_range(0, 7));
      build_exp(d, int'(r), g0 ? 0 : GAP, 0);
      run(d, r, 1, g0);
      for (int k = 0; k < exp_q.size(); k++) begin
        checks++;
        if (obs_q[k] !== exp_q[k]) begin
          errors++;
          $display("FAIL random_%0d g0=%0d d=%b r=%0d cyc %0d got %b exp %b", t, g0, d, r, k + 1, obs_q[k], exp_q[k]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_gap0();
    test_start_ignored();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
